// File: rtl/mgt_01_fp_round_unit_pkg.sv
// rtl/mgt_01_fp_round_unit_pkg.sv - shared types and constants for the FP rounding stage
package mgt_01_fp_round_unit_pkg;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float_t;

  typedef enum logic [2:0] {
    RNE = 3'd0,
    RTZ = 3'd1,
    RDN = 3'd2,
    RUP = 3'd3,
    RMM = 3'd4
  } rnd_mode_t;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fflags_t;

  localparam logic [31:0] CANO_NAN   = 32'h7FC0_0000;
  localparam logic [31:0] P_INFTY    = 32'h7F80_0000;
  localparam logic [31:0] N_INFTY    = 32'hFF80_0000;
  localparam logic [30:0] MAX_FINITE = 31'h7F7F_FFFF;

  // Magnitude of a signed overflow result: infinity when rounding away, else max finite.
  function automatic logic [31:0] ovf_result(input logic sign, input logic to_inf);
    if (to_inf) begin
      return sign ? N_INFTY : P_INFTY;
    end
    return {sign, MAX_FINITE};
  endfunction

endpackage

// File: rtl/mgt_01_round_incr.sv
// rtl/mgt_01_round_incr.sv - combinational increment decision for one rounding mode
module mgt_01_round_incr
  import mgt_01_fp_round_unit_pkg::*;
(
  input  logic       sign,
  input  logic       lsb,
  input  logic [2:0] grs,
  input  logic [2:0] mode,
  output logic       increment,
  output logic       inexact,
  output logic       bad_mode
);

  logic guard_bit;
  logic round_bit;
  logic sticky_bit;

  assign guard_bit  = grs[2];
  assign round_bit  = grs[1];
  assign sticky_bit = grs[0];

  // Decide whether the truncated mantissa must be bumped by one ulp; reserved modes fall back to RNE.
  always_comb begin
    increment = 1'b0;
    inexact   = guard_bit | round_bit | sticky_bit;
    bad_mode  = (mode > 3'd4);
    case (rnd_mode_t'(mode))
      RTZ:     increment = 1'b0;
      RDN:     increment = sign & inexact;
      RUP:     increment = ~sign & inexact;
      RMM:     increment = guard_bit;
      default: increment = guard_bit & (round_bit | sticky_bit | lsb);
    endcase
  end

endmodule

// File: rtl/mgt_01_fp_round_unit.sv
// rtl/mgt_01_fp_round_unit.sv - two-stage IEEE-754 single rounding stage; optional MGT_FP_FFLAGS_ACC_EN flag accumulator
module mgt_01_fp_round_unit
  import mgt_01_fp_round_unit_pkg::*;
#(
  parameter logic [31:0] CANON_NAN_VAL = CANO_NAN
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clk_en_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] to_round_unit_i,
  input  logic [2:0]  round_bits_i,
  input  logic [2:0]  rounding_mode_i,
  input  logic        invalid_op_i,
  input  logic        overflow_i,
  input  logic        underflow_i,
`ifdef MGT_FP_FFLAGS_ACC_EN
  input  logic        fflags_clear_i,
  output logic [4:0]  fflags_o,
`endif
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] result_o,
  output logic        invalid_o,
  output logic        overflow_o,
  output logic        underflow_o,
  output logic        inexact_o
);

  // Pipeline control
  logic s1_valid;
  logic s2_valid;
  logic s1_advance;
  logic s2_load;

  // Stage 1 state
  float_t    s1_op;
  rnd_mode_t s1_mode;
  logic      s1_inc;
  logic      s1_inx;
  logic      s1_bad;
  logic      s1_inv;
  logic      s1_ovf;
  logic      s1_unf;

  // Stage 1 combinational decision
  logic in_inc;
  logic in_inx;
  logic in_bad;

  // Stage 2 combinational result
  logic [30:0] rnd_mag;
  logic        is_special;
  logic        is_nan;
  logic        ovf_hit;
  logic        to_inf;
  logic [31:0] nxt_result;
  logic        nxt_inexact;

  assign s1_advance = ~s2_valid | ready_i;
  assign ready_o    = clk_en_i & (~s1_valid | s1_advance);
  assign s2_load    = clk_en_i & s1_advance;
  assign valid_o    = s2_valid;

  mgt_01_round_incr u_round_incr (
    .sign      (to_round_unit_i[31]),
    .lsb       (to_round_unit_i[0]),
    .grs       (round_bits_i),
    .mode      (rounding_mode_i),
    .increment (in_inc),
    .inexact   (in_inx),
    .bad_mode  (in_bad)
  );

  // Stage 1: capture operand, effective mode, upstream flags and the increment decision.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_mode  <= RNE;
      s1_inc   <= 1'b0;
      s1_inx   <= 1'b0;
      s1_bad   <= 1'b0;
      s1_inv   <= 1'b0;
      s1_ovf   <= 1'b0;
      s1_unf   <= 1'b0;
    end else if (ready_o) begin
      s1_valid <= valid_i;
      if (valid_i) begin
        s1_op    <= to_round_unit_i;
        s1_mode  <= in_bad ? RNE : rnd_mode_t'(rounding_mode_i);
        s1_inc   <= in_inc;
        s1_inx   <= in_inx;
        s1_bad   <= in_bad;
        s1_inv   <= invalid_op_i;
        s1_ovf   <= overflow_i;
        s1_unf   <= underflow_i;
      end
    end
  end

  // The mantissa increment ripples into the exponent, which covers both mantissa carry-out and subnormal promotion.
  assign rnd_mag    = s1_op[30:0] + {30'd0, s1_inc};
  assign is_special = (s1_op.exponent == 8'hFF);
  assign is_nan     = is_special & (s1_op.mantissa != 23'd0);
  assign ovf_hit    = ~is_special & ((rnd_mag[30:23] == 8'hFF) | s1_ovf);

  // Stage 2 combinational: choose the final encoding and the inexact flag.
  always_comb begin
    to_inf      = 1'b0;
    nxt_result  = {s1_op.sign, rnd_mag};
    nxt_inexact = s1_inx;
    case (s1_mode)
      RTZ:     to_inf = 1'b0;
      RDN:     to_inf = s1_op.sign;
      RUP:     to_inf = ~s1_op.sign;
      default: to_inf = 1'b1;
    endcase
    if (is_special) begin
      nxt_result  = is_nan ? CANON_NAN_VAL : s1_op;
      nxt_inexact = 1'b0;
    end else if (ovf_hit) begin
      nxt_result  = ovf_result(s1_op.sign, to_inf);
      nxt_inexact = 1'b1;
    end
  end

  // Stage 2: output register; holds while the downstream stalls or the clock enable is low.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s2_valid    <= 1'b0;
      result_o    <= '0;
      invalid_o   <= 1'b0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      inexact_o   <= 1'b0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        result_o    <= nxt_result;
        invalid_o   <= s1_inv | s1_bad;
        overflow_o  <= ovf_hit;
        underflow_o <= s1_unf & nxt_inexact;
        inexact_o   <= nxt_inexact;
      end
    end
  end

`ifdef MGT_FP_FFLAGS_ACC_EN
  fflags_t acc_flags;

  // Sticky accumulation of flags on each beat taken downstream; clear wins over a same-cycle set.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      acc_flags <= '0;
    end else if (clk_en_i) begin
      if (fflags_clear_i) begin
        acc_flags <= '0;
      end else if (s2_valid & ready_i) begin
        acc_flags.nv <= acc_flags.nv | invalid_o;
        acc_flags.dz <= 1'b0;
        acc_flags.of <= acc_flags.of | overflow_o;
        acc_flags.uf <= acc_flags.uf | underflow_o;
        acc_flags.nx <= acc_flags.nx | inexact_o;
      end
    end
  end

  assign fflags_o = acc_flags;
`endif

endmodule

// File: tb/tb_mgt_01_fp_round_unit.sv
// tb/tb_mgt_01_fp_round_unit.sv - self-checking bench for the FP rounding stage
module tb_mgt_01_fp_round_unit;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        clk_en_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] to_round_unit_i;
  logic [2:0]  round_bits_i;
  logic [2:0]  rounding_mode_i;
  logic        invalid_op_i;
  logic        overflow_i;
  logic        underflow_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        invalid_o;
  logic        overflow_o;
  logic        underflow_o;
  logic        inexact_o;
`ifdef MGT_FP_FFLAGS_ACC_EN
  logic        fflags_clear_i;
  logic [4:0]  fflags_o;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk_i = ~clk_i;

  mgt_01_fp_round_unit dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .clk_en_i        (clk_en_i),
    .valid_i         (valid_i),
    .ready_o         (ready_o),
    .to_round_unit_i (to_round_unit_i),
    .round_bits_i    (round_bits_i),
    .rounding_mode_i (rounding_mode_i),
    .invalid_op_i    (invalid_op_i),
    .overflow_i      (overflow_i),
    .underflow_i     (underflow_i),
`ifdef MGT_FP_FFLAGS_ACC_EN
    .fflags_clear_i  (fflags_clear_i),
    .fflags_o        (fflags_o),
`endif
    .valid_o         (valid_o),
    .ready_i         (ready_i),
    .result_o        (result_o),
    .invalid_o       (invalid_o),
    .overflow_o      (overflow_o),
    .underflow_o     (underflow_o),
    .inexact_o       (inexact_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: treat GRS as a 3-bit fraction of an ulp and compare it against one half.
  function automatic logic [35:0] ref_round(input logic [31:0] op, input logic [2:0] grs,
                                            input logic [2:0] mode, input logic inv_i,
                                            input logic ovf_i, input logic unf_i);
    int          m;
    int          frac;
    longint      mag;
    bit          neg;
    bit          up;
    bit          away;
    logic [31:0] res;
    logic        nv, of, uf, nx;
    m    = (mode > 3'd4) ? 0 : int'(mode);
    nv   = inv_i | (mode > 3'd4);
    neg  = op[31];
    mag  = longint'(op[30:0]);
    frac = int'(grs);
    of   = 1'b0;
    uf   = 1'b0;
    if (op[30:23] == 8'hFF) begin
      res = (op[22:0] != 0) ? 32'h7FC00000 : op;
      nx  = 1'b0;
    end else begin
      nx = (frac != 0);
      case (m)
        0:       up = (frac > 4) || (frac == 4 && (mag % 2) == 1);
        1:       up = 1'b0;
        2:       up = neg && frac != 0;
        3:       up = !neg && frac != 0;
        default: up = (frac >= 4);
      endcase
      mag = mag + (up ? 1 : 0);
      if (mag >= 64'h7F800000 || ovf_i) begin
        away = (m == 0) || (m == 4) || (m == 2 && neg) || (m == 3 && !neg);
        res  = {neg, away ? 31'h7F800000 : 31'h7F7FFFFF};
        of   = 1'b1;
        nx   = 1'b1;
      end else begin
        res = {neg, mag[30:0]};
      end
    end
    uf = unf_i & nx;
    return {nv, of, uf, nx, res};
  endfunction

  function automatic logic [35:0] dut_out();
    return {invalid_o, overflow_o, underflow_o, inexact_o, result_o};
  endfunction

  task automatic drive_beat(input logic [31:0] op, input logic [2:0] grs, input logic [2:0] mode,
                            input logic inv, input logic ovf, input logic unf);
    to_round_unit_i = op;
    round_bits_i    = grs;
    rounding_mode_i = mode;
    invalid_op_i    = inv;
    overflow_i      = ovf;
    underflow_i     = unf;
  endtask

  // One beat through an empty, unstalled pipe; checks latency, result and flags {NV,OF,UF,NX}.
  task automatic directed(input string tag, input logic [31:0] op, input logic [2:0] grs,
                          input logic [2:0] mode, input logic inv, input logic ovf, input logic unf,
                          input logic [31:0] exp_res, input logic [3:0] exp_flg);
    int waitc;
    int lat;
    @(negedge clk_i);
    drive_beat(op, grs, mode, inv, ovf, unf);
    clk_en_i = 1'b1;
    ready_i  = 1'b1;
    valid_i  = 1'b1;
    waitc    = 0;
    #1;
    while (!ready_o && waitc < 10) begin
      @(negedge clk_i);
      #1;
      waitc++;
    end
    if (!ready_o) check({tag, " accept timeout"}, 0, 1);
    @(negedge clk_i);
    valid_i = 1'b0;
    lat = 1;
    #1;
    while (!valid_o && lat < 8) begin
      @(negedge clk_i);
      lat++;
      #1;
    end
    check({tag, " latency"}, lat, 2);
    check({tag, " result"}, result_o, exp_res);
    check({tag, " flags"}, {invalid_o, overflow_o, underflow_o, inexact_o}, exp_flg);
  endtask

  task automatic test_backpressure();
    logic [31:0] bp_op [4];
    logic [31:0] held;
    int sent;
    int got;
    bp_op[0] = 32'h3F800000;
    bp_op[1] = 32'h40490FDB;
    bp_op[2] = 32'hC0000000;
    bp_op[3] = 32'h00000005;
    sent = 0;
    got  = 0;
    held = '0;
    for (int c = 0; c < 30 && got < 4; c++) begin
      @(negedge clk_i);
      clk_en_i = 1'b1;
      valid_i  = (sent < 4);
      if (sent < 4) drive_beat(bp_op[sent], 3'b000, 3'd1, 1'b0, 1'b0, 1'b0);
      ready_i = (c >= 5);
      #1;
      if (c == 2) begin
        check("bp ready_o drop", ready_o, 0);
        check("bp beats buffered", sent, 2);
        held = result_o;
      end
      if (c == 3 || c == 4) begin
        check("bp valid held", valid_o, 1);
        check("bp result held", result_o, held);
      end
      if (valid_i && ready_o) sent++;
      if (valid_o && ready_i) begin
        check("bp order", result_o, bp_op[got]);
        got++;
      end
    end
    check("bp all delivered", got, 4);
    @(negedge clk_i);
    valid_i = 1'b0;
  endtask

  task automatic test_reset_flush();
    @(negedge clk_i);
    clk_en_i = 1'b1;
    ready_i  = 1'b0;
    valid_i  = 1'b1;
    drive_beat(32'h3F800000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    drive_beat(32'h40000000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk_i);
    valid_i = 1'b0;
    #1;
    check("rst precondition valid_o", valid_o, 1);
    rst_n_i = 1'b0;
    #1;
    check("rst async valid_o", valid_o, 0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    ready_i = 1'b1;
    #1;
    check("rst valid_o next cycle", valid_o, 0);
    check("rst result cleared", result_o, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      #1;
      check("rst no ghost", valid_o, 0);
    end
  endtask

  task automatic test_clk_en();
    @(negedge clk_i);
    clk_en_i = 1'b1;
    ready_i  = 1'b1;
    valid_i  = 1'b1;
    drive_beat(32'h3F800000, 3'b101, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check("en accept", ready_o, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      valid_i  = 1'b0;
      clk_en_i = 1'b0;
      #1;
      check("en frozen ready_o", ready_o, 0);
      check("en frozen valid_o", valid_o, 0);
    end
    @(negedge clk_i);
    clk_en_i = 1'b1;
    #1;
    check("en resumed still in s1", valid_o, 0);
    @(negedge clk_i);
    #1;
    check("en resumed valid_o", valid_o, 1);
    check("en resumed result", result_o, 32'h3F800001);
  endtask

  task automatic test_random();
    logic [35:0] q [$];
    logic [35:0] prev_out;
    logic [31:0] op;
    logic [2:0]  grs;
    logic [2:0]  mode;
    logic        inv, ovf, unf;
    bit          prev_stall;
    prev_stall = 1'b0;
    prev_out   = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk_i);
      op = $urandom;
      case ($urandom_range(0, 4))
        0: ;
        1: op[30:0] = {8'hFE, 23'h7FFFFF - 23'($urandom_range(0, 3))};
        2: op[30:23] = 8'hFF;
        3: op[30:23] = 8'h00;
        default: op[22:0] = 23'h7FFFFF;
      endcase
      if (op[30:23] == 8'hFF && $urandom_range(0, 1) == 0) op[22:0] = '0;
      grs  = 3'($urandom_range(0, 7));
      mode = 3'($urandom_range(0, 7));
      inv  = ($urandom_range(0, 7) == 0);
      ovf  = ($urandom_range(0, 7) == 0);
      unf  = ($urandom_range(0, 3) == 0);
      drive_beat(op, grs, mode, inv, ovf, unf);
      clk_en_i = ($urandom_range(0, 9) != 0);
      valid_i  = ($urandom_range(0, 2) != 0);
      ready_i  = ($urandom_range(0, 3) != 0);
      #1;
      if (prev_stall) begin
        check("rand stall valid held", valid_o, 1);
        check("rand stall output held", dut_out(), prev_out);
      end
      if (!clk_en_i) check("rand disabled ready_o", ready_o, 0);
      if (clk_en_i && valid_i && ready_o) q.push_back(ref_round(op, grs, mode, inv, ovf, unf));
      if (clk_en_i && valid_o && ready_i) begin
        if (q.size() == 0) check("rand unexpected output", 1, 0);
        else check("rand result", dut_out(), q.pop_front());
      end
      prev_stall = valid_o && !(clk_en_i && ready_i);
      prev_out   = dut_out();
    end
    for (int d = 0; d < 10; d++) begin
      @(negedge clk_i);
      clk_en_i = 1'b1;
      valid_i  = 1'b0;
      ready_i  = 1'b1;
      #1;
      if (valid_o) begin
        if (q.size() == 0) check("drain unexpected output", 1, 0);
        else check("drain result", dut_out(), q.pop_front());
      end
    end
    check("drain queue empty", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n_i  = 1'b0;
    clk_en_i = 1'b1;
    valid_i  = 1'b0;
    ready_i  = 1'b0;
    drive_beat(32'h0, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0);
`ifdef MGT_FP_FFLAGS_ACC_EN
    fflags_clear_i = 1'b0;
`endif
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    check("reset valid_o", valid_o, 0);
    check("reset result_o", result_o, 0);
    check("reset flags", {invalid_o, overflow_o, underflow_o, inexact_o}, 0);
    check("reset ready_o", ready_o, 1);
`ifdef MGT_FP_FFLAGS_ACC_EN
    check("reset fflags_o", fflags_o, 0);
`endif
    @(negedge clk_i);
    rst_n_i = 1'b1;

    directed("rne tie even",    32'h3F800000, 3'b100, 3'd0, 0, 0, 0, 32'h3F800000, 4'b0001);
    directed("rne tie odd",     32'h3F800001, 3'b100, 3'd0, 0, 0, 0, 32'h3F800002, 4'b0001);
    directed("rne above half",  32'h3F800000, 3'b101, 3'd0, 0, 0, 0, 32'h3F800001, 4'b0001);
    directed("rmm tie",         32'h3F800000, 3'b100, 3'd4, 0, 0, 0, 32'h3F800001, 4'b0001);
    directed("rup carry",       32'h3FFFFFFF, 3'b110, 3'd3, 0, 0, 0, 32'h40000000, 4'b0001);
    directed("rtz no carry",    32'h3FFFFFFF, 3'b110, 3'd1, 0, 0, 0, 32'h3FFFFFFF, 4'b0001);
    directed("subnormal carry", 32'h007FFFFF, 3'b100, 3'd0, 0, 0, 0, 32'h00800000, 4'b0001);
    directed("underflow inx",   32'h00000001, 3'b010, 3'd0, 0, 0, 1, 32'h00000001, 4'b0011);
    directed("ovf rne",         32'h7F7FFFFF, 3'b100, 3'd0, 0, 0, 0, 32'h7F800000, 4'b0101);
    directed("ovf rtz",         32'h7F7FFFFF, 3'b100, 3'd1, 0, 1, 0, 32'h7F7FFFFF, 4'b0101);
    directed("ovf rdn neg",     32'hFF7FFFFF, 3'b100, 3'd2, 0, 0, 0, 32'hFF800000, 4'b0101);
    directed("ovf rup neg",     32'hFF7FFFFF, 3'b100, 3'd3, 0, 1, 0, 32'hFF7FFFFF, 4'b0101);
    directed("snan canon",      32'h7FA00000, 3'b000, 3'd0, 1, 0, 0, 32'h7FC00000, 4'b1000);
    directed("neg inf pass",    32'hFF800000, 3'b111, 3'd0, 0, 1, 1, 32'hFF800000, 4'b0000);
    directed("reserved mode",   32'h3F800000, 3'b000, 3'd6, 0, 0, 0, 32'h3F800000, 4'b1000);

    test_backpressure();
    test_clk_en();
    test_reset_flush();

`ifdef MGT_FP_FFLAGS_ACC_EN
    @(negedge clk_i);
    fflags_clear_i = 1'b1;
    @(negedge clk_i);
    fflags_clear_i = 1'b0;
    #1;
    check("acc cleared", fflags_o, 0);
    directed("acc ovf beat", 32'h7F7FFFFF, 3'b100, 3'd0, 0, 0, 0, 32'h7F800000, 4'b0101);
    directed("acc inx beat", 32'h3F800000, 3'b101, 3'd0, 0, 0, 0, 32'h3F800001, 4'b0001);
    @(negedge clk_i);
    #1;
    check("acc of nx", fflags_o, 5'b00101);
    @(negedge clk_i);
    fflags_clear_i = 1'b1;
    @(negedge clk_i);
    fflags_clear_i = 1'b0;
    #1;
    check("acc clear", fflags_o, 5'b00000);
`endif

    test_random();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
